timer_prescaler: RTL and testbench
==================================

Name: timer_prescaler

Overview:
Tick generator that sits directly upstream of the timer counter and drives its clk_pulse input. It produces single-cycle enable pulses from one of two sources: an internal programmable divider, or edges on an external event pin. Pulses run either continuously or as a burst of N pulses that ends automatically. busy and done status outputs let the control logic sequence timer runs.

Parameters:
DIV_SIZE, 8, width of divide value and internal prescale counter
BURST_SIZE, 8, width of burst length and internal burst counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low forces IDLE
start  in  1  level sampled each edge; in IDLE with enable=1 starts a run
stop  in  1  aborts a run; wins over start
src_sel  in  1  0 = internal divider, 1 = external event
edge_sel  in  1  0 = rising edge of ext_evt, 1 = falling edge
ext_evt  in  1  external event input, asynchronous to clk
div  in  DIV_SIZE  pulse period is div+1 clocks (internal mode)
burst_len  in  BURST_SIZE  pulses per run; 0 = continuous
clk_pulse  out  1  registered tick to downstream counter
busy  out  1  high while state is RUN
done  out  1  one-cycle pulse, concurrent with the final pulse of a burst

Behaviour:
- Reset (rst_n low, async): state=IDLE; prescale cnt=0, burst cnt=0, sync/edge flops=0; clk_pulse=0, busy=0, done=0.
- States: IDLE, RUN. All outputs are registered.
- IDLE->RUN at an edge where enable=1, start=1, stop=0.
  - div, burst_len, src_sel and edge_sel are latched (div_q, len_q, src_q, edge_q).
  - cnt=0, bcnt=0, busy=1 after that edge.
  - Input changes during RUN are ignored until the next start.
- start while in RUN: ignored; no restart.
- RUN->IDLE, abort: at any edge with stop=1 or enable=0.
  - clk_pulse=0, busy=0, done=0 after the edge; counters cleared.
- Internal mode (src_q=0), at each RUN edge:
  - if cnt==div_q: cnt<=0 and pulse event; else cnt<=cnt+1, no event.
  - First pulse is high during the cycle after edge E0+div_q+1, where E0 is the start edge.
  - Period is div_q+1 clocks. div_q=0 gives clk_pulse high every RUN cycle.
- External mode (src_q=1):
  - ext_evt passes through a 2-flop synchronizer, then a history flop.
  - Edge detect = sync & ~hist (rising) or ~sync & hist (falling).
  - A detected edge sets clk_pulse for one cycle. Latency from ext_evt transition to clk_pulse high is 3 edges.
  - Synchronizer and history flops run in all states. Edges detected in IDLE generate nothing.
- Pulse event: clk_pulse<=1 for exactly one cycle (except the div_q=0 continuous case).
- Burst counting (len_q!=0):
  - bcnt increments on each pulse event.
  - On the event where bcnt==len_q-1: clk_pulse<=1, done<=1, state<=IDLE, busy<=0, all at the same edge.
  - len_q=0: bcnt does not count; run is unbounded.
- stop on the same edge as the final pulse event: stop wins; no pulse, no done.
- Reset mid-run: immediate IDLE; no done.

Optional Feature:
Macro TIMER_PRESCALER_EXT_SYNC_EN.
- Defined: 2-flop synchronizer on ext_evt as above; external latency 3 edges.
- Undefined: ext_evt is taken as already synchronous to clk; synchronizer removed and the history flop compares ext_evt directly. External latency is 1 edge (clk_pulse high after the first edge that sees the transition).

Test Plan:
- Reset: hold rst_n=0 mid-run -> clk_pulse=0, busy=0, done=0 immediately; no pulses until a new start.
- Internal continuous: div=3, burst_len=0, start at E0 -> clk_pulse high after E4, E8, E12…; busy stays 1; stop at E10 -> no pulse at E12, busy=0 after E10.
- Internal burst: div=1, burst_len=3 -> exactly 3 pulses after E2, E4, E6; done high only after E6; busy=0 after E6.
- div=0, burst_len=4 -> clk_pulse high for 4 consecutive cycles, done on the 4th; changing div during the run has no effect.
- External rising, sync enabled: src_sel=1, edge_sel=0, burst_len=2, ext_evt toggled 0->1->0->1 -> a pulse 3 edges after each rising edge, none on falling; done with the 2nd pulse.
- Conflicts: start=1 and stop=1 in IDLE -> stays IDLE. stop coincident with the final burst pulse -> no pulse, no done. Edges in IDLE -> no pulses.

Source files
------------

// File: rtl/timer_prescaler.sv
// Tick generator for the timer counter: one-cycle enable pulses from an internal divider or
// external event edges, continuous or as an N-pulse burst. Macro TIMER_PRESCALER_EXT_SYNC_EN
// adds a 2-flop synchronizer on ext_evt.
module timer_prescaler #(
  parameter int unsigned DIV_SIZE   = 8,
  parameter int unsigned BURST_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  src_sel,
  input  logic                  edge_sel,
  input  logic                  ext_evt,
  input  logic [DIV_SIZE-1:0]   div,
  input  logic [BURST_SIZE-1:0] burst_len,
  output logic                  clk_pulse,
  output logic                  busy,
  output logic                  done
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [DIV_SIZE-1:0]   DivOne   = 1;
  localparam logic [BURST_SIZE-1:0] BurstOne = 1;

  logic                  state_q, state_d;
  logic [DIV_SIZE-1:0]   cnt_q, cnt_d;
  logic [BURST_SIZE-1:0] bcnt_q, bcnt_d;
  logic [DIV_SIZE-1:0]   div_q, div_d;
  logic [BURST_SIZE-1:0] len_q, len_d;
  logic                  src_q, src_d;
  logic                  edge_q, edge_d;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hist_q;
  logic                  evt_s;
  logic                  edge_det;
  logic                  tick;

`ifdef TIMER_PRESCALER_EXT_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ext_evt;
      sync2_q <= sync1_q;
    end
  end

  assign evt_s = sync2_q;
`else
  assign evt_s = ext_evt;
`endif

  // History flop runs in every state so no stale edge fires right after a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= evt_s;
    end
  end

  assign edge_det = edge_q ? (~evt_s & hist_q) : (evt_s & ~hist_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    div_d   = div_q;
    len_d   = len_q;
    src_d   = src_q;
    edge_d  = edge_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    tick    = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable && start && !stop) begin
          state_d = StRun;
          div_d   = div;
          len_d   = burst_len;
          src_d   = src_sel;
          edge_d  = edge_sel;
          cnt_d   = '0;
          bcnt_d  = '0;
        end
      end
      default: begin
        if (stop || !enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          bcnt_d  = '0;
        end else begin
          if (src_q) begin
            tick = edge_det;
          end else begin
            tick  = (cnt_q == div_q);
            cnt_d = tick ? '0 : cnt_q + DivOne;
          end
          if (tick) begin
            pulse_d = 1'b1;
            if (len_q != '0) begin
              if (bcnt_q == len_q - BurstOne) begin
                done_d  = 1'b1;
                state_d = StIdle;
                cnt_d   = '0;
                bcnt_d  = '0;
              end else begin
                bcnt_d = bcnt_q + BurstOne;
              end
            end
          end
        end
      end
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      div_q   <= '0;
      len_q   <= '0;
      src_q   <= 1'b0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      div_q   <= div_d;
      len_q   <= len_d;
      src_q   <= src_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clk_pulse = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: reset, internal continuous/burst, external edges and
// start/stop conflicts; expected values are hand-derived edge numbers.
module tb_timer_prescaler;

`ifdef TIMER_PRESCALER_EXT_SYNC_EN
  localparam int ExtLat = 3;
`else
  localparam int ExtLat = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic       stop;
  logic       src_sel;
  logic       edge_sel;
  logic       ext_evt;
  logic [7:0] div;
  logic [7:0] burst_len;
  logic       clk_pulse;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  timer_prescaler #(
    .DIV_SIZE  (8),
    .BURST_SIZE(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .src_sel  (src_sel),
    .edge_sel (edge_sel),
    .ext_evt  (ext_evt),
    .div      (div),
    .burst_len(burst_len),
    .clk_pulse(clk_pulse),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic s, input logic e, input logic [7:0] d,
                           input logic [7:0] l);
    src_sel   = s;
    edge_sel  = e;
    div       = d;
    burst_len = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({clk_pulse, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_init: got %b want 000", {clk_pulse, busy, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Mid-run reset while div=0 keeps clk_pulse high every cycle.
    start_run(1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    n_checks++;
    if ({clk_pulse, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_prerun: got %b want 11", {clk_pulse, busy});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clk_pulse, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 000", {clk_pulse, busy, done});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({clk_pulse, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_after k=%0d: got %b want 000", k, {clk_pulse, busy, done});
      end
    end
  endtask

  task automatic test_internal_continuous();
    start_run(1'b0, 1'b0, 8'd3, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if ({clk_pulse, busy, done} !== {(k % 4 == 0), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL cont E%0d: got %b want %b", k, {clk_pulse, busy, done},
                 {(k % 4 == 0), 1'b1, 1'b0});
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({clk_pulse, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL cont_stop E10: got %b want 000", {clk_pulse, busy, done});
    end
    for (int k = 11; k <= 13; k++) begin
      tick();
      n_checks++;
      if ({clk_pulse, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL cont_after E%0d: got %b want 00", k, {clk_pulse, busy});
      end
    end
  endtask

  task automatic test_internal_burst();
    logic [2:0] exp;
    start_run(1'b0, 1'b0, 8'd1, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k == 2 || k == 4 || k == 6), (k < 6), (k == 6)};
      n_checks++;
      if ({clk_pulse, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL burst E%0d: got %b want %b", k, {clk_pulse, busy, done}, exp);
      end
    end
  endtask

  task automatic test_div0_burst();
    logic [2:0] exp;
    start_run(1'b0, 1'b0, 8'd0, 8'd4);
    div = 8'd5;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = {(k <= 4), (k < 4), (k == 4)};
      n_checks++;
      if ({clk_pulse, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL div0 E%0d: got %b want %b", k, {clk_pulse, busy, done}, exp);
      end
    end
  endtask

  task automatic test_external_rising();
    logic [2:0] exp;
    start_run(1'b1, 1'b0, 8'd0, 8'd2);
    for (int k = 1; k <= 14; k++) begin
      ext_evt = ((k >= 1 && k < 5) || k >= 9);
      tick();
      exp = {(k == ExtLat || k == 8 + ExtLat), (k < 8 + ExtLat), (k == 8 + ExtLat)};
      n_checks++;
      if ({clk_pulse, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL ext_rise E%0d: got %b want %b", k, {clk_pulse, busy, done}, exp);
      end
    end
  endtask

  task automatic test_external_falling();
    logic [2:0] exp;
    // ext_evt is still high here; fall before E3, rise before E7.
    start_run(1'b1, 1'b1, 8'd0, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      ext_evt = !(k >= 3 && k < 7);
      tick();
      exp = {(k == 2 + ExtLat), (k < 2 + ExtLat), (k == 2 + ExtLat)};
      n_checks++;
      if ({clk_pulse, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL ext_fall E%0d: got %b want %b", k, {clk_pulse, busy, done}, exp);
      end
    end
    ext_evt = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_conflicts();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if ({clk_pulse, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_stop_idle: got %b want 00", {clk_pulse, busy});
    end
    // Burst of 2 at div=1: pulses after E2 and E4; stop lands on E4.
    start_run(1'b0, 1'b0, 8'd1, 8'd2);
    tick();
    tick();
    n_checks++;
    if ({clk_pulse, busy, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL stop_final E2: got %b want 110", {clk_pulse, busy, done});
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({clk_pulse, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL stop_final E4: got %b want 000", {clk_pulse, busy, done});
    end
    // Abort by dropping enable.
    start_run(1'b0, 1'b0, 8'd0, 8'd0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    n_checks++;
    if ({clk_pulse, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL enable_abort: got %b want 00", {clk_pulse, busy});
    end
    // Edges while idle must not tick.
    src_sel = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ext_evt = k[0];
      tick();
      n_checks++;
      if ({clk_pulse, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_edges k=%0d: got %b want 000", k, {clk_pulse, busy, done});
      end
    end
    ext_evt = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    src_sel   = 1'b0;
    edge_sel  = 1'b0;
    ext_evt   = 1'b0;
    div       = 8'd0;
    burst_len = 8'd0;
    test_reset();
    test_internal_continuous();
    test_internal_burst();
    test_div0_burst();
    test_external_rising();
    test_external_falling();
    test_conflicts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
